phase_diff_decimator: RTL and testbench

- Sits directly downstream of a pair of PHASEMETER_V3 channels.
- Consumes each channel's PI action, a frequency-offset word in NCO phase-increment units.
- Integrates each channel to an unwrapped phase, forms the A−B differential phase, and decimates by 2^DEC_LOG2.
- Emits each decimated sample as a two-beat AXI-Stream packet with sequence number and overflow reporting.

---
 rtl/phase_diff_pkg.sv | 28 ++
 rtl/phase_diff_decimator_if.sv | 30 +++
 rtl/phase_integrator.sv | 37 +++
 rtl/phase_diff_decimator.sv | 163 ++++++++++++++++
 tb/tb_phase_diff_decimator.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/phase_diff_pkg.sv
// Shared types and field layout for the A-B differential phase decimator.
// Output beat 0 carries the sequence number above the sign-extended phase MSBs.
package phase_diff_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_e;

  localparam int SEQ_WIDTH      = 16;
  localparam int BEAT_WIDTH     = 32;
  localparam int BEAT0_SEQ_LSB  = 16;
  localparam int BEAT0_HI_WIDTH = 16;
  localparam int SNAP_HI_LSB    = 32;

  function automatic logic [BEAT_WIDTH-1:0] pack_beat0(
    input logic [SEQ_WIDTH-1:0]      seq,
    input logic [BEAT0_HI_WIDTH-1:0] hi
  );
    logic [BEAT_WIDTH-1:0] beat;
    beat = '0;
    beat[BEAT0_SEQ_LSB +: SEQ_WIDTH] = seq;
    beat[0 +: BEAT0_HI_WIDTH]        = hi;
    return beat;
  endfunction

endpackage

// File: rtl/phase_diff_decimator_if.sv
// Stream bundle for the decimator: two PI input streams and the phase output stream.
// slave = decimator side, master = environment side.
interface phase_diff_decimator_if #(
  parameter int AXIS_TDATA_WIDTH = 32
);

  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_PI_A_tdata;
  logic                        S_AXIS_PI_A_tvalid;
  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_PI_B_tdata;
  logic                        S_AXIS_PI_B_tvalid;
  logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_PHASE_tdata;
  logic                        M_AXIS_PHASE_tvalid;
  logic                        M_AXIS_PHASE_tready;
  logic                        M_AXIS_PHASE_tlast;

  modport slave (
    input  S_AXIS_PI_A_tdata, S_AXIS_PI_A_tvalid,
    input  S_AXIS_PI_B_tdata, S_AXIS_PI_B_tvalid,
    input  M_AXIS_PHASE_tready,
    output M_AXIS_PHASE_tdata, M_AXIS_PHASE_tvalid, M_AXIS_PHASE_tlast
  );

  modport master (
    output S_AXIS_PI_A_tdata, S_AXIS_PI_A_tvalid,
    output S_AXIS_PI_B_tdata, S_AXIS_PI_B_tvalid,
    output M_AXIS_PHASE_tready,
    input  M_AXIS_PHASE_tdata, M_AXIS_PHASE_tvalid, M_AXIS_PHASE_tlast
  );

endinterface

// File: rtl/phase_integrator.sv
// Single-channel signed phase accumulator; acc_nxt already includes the current sample
// so a snapshot taken on the final accept of a block sees it.
module phase_integrator #(
  parameter int IN_WIDTH    = 32,
  parameter int PHASE_WIDTH = 48
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   accept,
  input  logic [IN_WIDTH-1:0]    din,
  output logic [PHASE_WIDTH-1:0] acc_nxt
);

  logic [PHASE_WIDTH-1:0] acc_q;
  logic [PHASE_WIDTH-1:0] acc_d;

  assign acc_nxt = acc_q + {{(PHASE_WIDTH-IN_WIDTH){din[IN_WIDTH-1]}}, din};

  always_comb begin
    acc_d = acc_q;
    if (!en) begin
      acc_d = '0;
    end else if (accept) begin
      acc_d = acc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/phase_diff_decimator.sv
// Integrates two PI streams to unwrapped phase, decimates A-B by 2^DEC_LOG2 and
// emits each snapshot as a two-beat packet with sequence number and drop flag.
//   state | meaning
//   IDLE  | no packet in flight
//   BEAT0 | presenting {seq, phase MSBs}
//   BEAT1 | presenting phase LSBs, tlast=1
module phase_diff_decimator
  import phase_diff_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int PHASE_WIDTH      = 48,
  parameter int DEC_LOG2         = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clear_ovf,
  output logic                    overflow,
  phase_diff_decimator_if.slave   axis
);

  logic                          accept;
  logic                          snap_evt;
  logic                          load;
  logic                          drop;
  logic [PHASE_WIDTH-1:0]        acc_a_nxt;
  logic [PHASE_WIDTH-1:0]        acc_b_nxt;
  logic signed [PHASE_WIDTH-1:0] snap;
  logic [BEAT0_HI_WIDTH-1:0]     snap_hi;

  logic [DEC_LOG2-1:0]   dec_cnt_q, dec_cnt_d;
  logic [SEQ_WIDTH-1:0]  seq_q, seq_d;
  state_e                state_q, state_d;
  logic [BEAT_WIDTH-1:0] hold_q, hold_d;
  logic [BEAT_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  overflow_q, overflow_d;

  assign accept   = en & axis.S_AXIS_PI_A_tvalid & axis.S_AXIS_PI_B_tvalid;
  assign snap_evt = accept && (dec_cnt_q == '1);

  phase_integrator #(
    .IN_WIDTH    (AXIS_TDATA_WIDTH),
    .PHASE_WIDTH (PHASE_WIDTH)
  ) u_int_a (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .accept  (accept),
    .din     (axis.S_AXIS_PI_A_tdata),
    .acc_nxt (acc_a_nxt)
  );

  phase_integrator #(
    .IN_WIDTH    (AXIS_TDATA_WIDTH),
    .PHASE_WIDTH (PHASE_WIDTH)
  ) u_int_b (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .accept  (accept),
    .din     (axis.S_AXIS_PI_B_tdata),
    .acc_nxt (acc_b_nxt)
  );

  // Arithmetic shift sign-extends the MSB field when PHASE_WIDTH < 48.
  assign snap    = acc_a_nxt - acc_b_nxt;
  assign snap_hi = BEAT0_HI_WIDTH'(snap >>> SNAP_HI_LSB);

  always_comb begin
    dec_cnt_d = dec_cnt_q;
    seq_d     = seq_q;
    if (!en) begin
      dec_cnt_d = '0;
      seq_d     = '0;
    end else if (accept) begin
      dec_cnt_d = dec_cnt_q + 1'b1;
      if (snap_evt) begin
        seq_d = seq_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    load     = 1'b0;
    drop     = 1'b0;
    case (state_q)
      IDLE: begin
        load = snap_evt;
      end
      BEAT0: begin
        drop = snap_evt;
        if (axis.M_AXIS_PHASE_tready) begin
          state_d = BEAT1;
          tdata_d = hold_q;
          tlast_d = 1'b1;
        end
      end
      BEAT1: begin
        if (axis.M_AXIS_PHASE_tready) begin
          // Handshake frees the slot this cycle, so a coincident snapshot chains on.
          load = snap_evt;
          if (!snap_evt) begin
            state_d  = IDLE;
            tdata_d  = '0;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
          end
        end else begin
          drop = snap_evt;
        end
      end
      default: begin
        state_d  = IDLE;
        tdata_d  = '0;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    endcase
    if (load) begin
      state_d  = BEAT0;
      hold_d   = snap[BEAT_WIDTH-1:0];
      tdata_d  = pack_beat0(seq_q, snap_hi);
      tvalid_d = 1'b1;
      tlast_d  = 1'b0;
    end
    overflow_d = drop ? 1'b1 : (clear_ovf ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_cnt_q  <= '0;
      seq_q      <= '0;
      state_q    <= IDLE;
      hold_q     <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      dec_cnt_q  <= dec_cnt_d;
      seq_q      <= seq_d;
      state_q    <= state_d;
      hold_q     <= hold_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      overflow_q <= overflow_d;
    end
  end

  assign axis.M_AXIS_PHASE_tdata  = tdata_q;
  assign axis.M_AXIS_PHASE_tvalid = tvalid_q;
  assign axis.M_AXIS_PHASE_tlast  = tlast_q;
  assign overflow                 = overflow_q;

endmodule

// File: tb/tb_phase_diff_decimator.sv
// Scoreboard bench for phase_diff_decimator with DEC_LOG2=2, PHASE_WIDTH=48.
module tb_phase_diff_decimator;

  localparam int DEC_LOG2 = 2;
  localparam int PW       = 48;
  localparam int DEC_LAST = (1 << DEC_LOG2) - 1;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic clear_ovf;
  logic overflow;

  phase_diff_decimator_if #(.AXIS_TDATA_WIDTH(32)) bus ();

  phase_diff_decimator #(
    .AXIS_TDATA_WIDTH (32),
    .PHASE_WIDTH      (PW),
    .DEC_LOG2         (DEC_LOG2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clear_ovf (clear_ovf),
    .overflow  (overflow),
    .axis      (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  beat_t       exp_q[$];
  logic [31:0] last_b0;
  logic [31:0] last_b1;

  logic [PW-1:0] m_acc_a, m_acc_b;
  int            m_cnt;
  logic [15:0]   m_seq;
  int            m_st;
  bit            m_ovf;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_acc_a = '0;
    m_acc_b = '0;
    m_cnt   = 0;
    m_seq   = '0;
    m_st    = 0;
    m_ovf   = 1'b0;
    exp_q.delete();
  endtask

  task automatic push_pkt(input logic [15:0] seq, input logic [PW-1:0] d);
    beat_t b;
    b.data = {seq, d[47:32]};
    b.last = 1'b0;
    exp_q.push_back(b);
    b.data = d[31:0];
    b.last = 1'b1;
    exp_q.push_back(b);
  endtask

  // Reference behaviour for one clock with the given inputs.
  task automatic model_cycle(input bit av, input bit bv, input logic [31:0] a,
                             input logic [31:0] b, input bit rdy, input bit e, input bit clr);
    bit            acc, snap, set;
    logic [PW-1:0] na, nb;
    acc  = e && av && bv;
    na   = m_acc_a + {{16{a[31]}}, a};
    nb   = m_acc_b + {{16{b[31]}}, b};
    snap = acc && (m_cnt == DEC_LAST);
    set  = 1'b0;
    case (m_st)
      0: if (snap) begin push_pkt(m_seq, na - nb); m_st = 1; end
      1: begin set = snap; if (rdy) m_st = 2; end
      default: begin
        if (rdy) begin
          if (snap) begin push_pkt(m_seq, na - nb); m_st = 1; end
          else m_st = 0;
        end else set = snap;
      end
    endcase
    m_ovf = set ? 1'b1 : (clr ? 1'b0 : m_ovf);
    if (!e) begin
      m_acc_a = '0; m_acc_b = '0; m_cnt = 0; m_seq = '0;
    end else if (acc) begin
      m_acc_a = na;
      m_acc_b = nb;
      m_cnt   = (m_cnt + 1) % (DEC_LAST + 1);
      if (snap) m_seq = m_seq + 16'd1;
    end
  endtask

  task automatic step(input bit av, input bit bv, input logic [31:0] a, input logic [31:0] b,
                      input bit rdy, input bit e = 1'b1, input bit clr = 1'b0);
    bus.S_AXIS_PI_A_tvalid  = av;
    bus.S_AXIS_PI_B_tvalid  = bv;
    bus.S_AXIS_PI_A_tdata   = a;
    bus.S_AXIS_PI_B_tdata   = b;
    bus.M_AXIS_PHASE_tready = rdy;
    en        = e;
    clear_ovf = clr;
    if (rst) model_cycle(av, bv, a, b, rdy, e, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic clean();
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    last_b0 = 32'hDEAD_BEEF;
    last_b1 = 32'hDEAD_BEEF;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
  endtask

  // Output monitor: pops the scoreboard on every handshake, checks hold-while-stalled.
  initial begin
    beat_t       e;
    bit          prev_stall;
    logic [31:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) check_eq("stall_stable", bus.M_AXIS_PHASE_tdata, prev_data);
        if (bus.M_AXIS_PHASE_tvalid && bus.M_AXIS_PHASE_tready) begin
          if (exp_q.size() == 0) begin
            check_eq("sb_unexpected_beat", bus.M_AXIS_PHASE_tdata, 32'h0);
          end else begin
            e = exp_q.pop_front();
            check_eq("sb_tdata", bus.M_AXIS_PHASE_tdata, e.data);
            check_eq("sb_tlast", bus.M_AXIS_PHASE_tlast, e.last);
          end
          if (bus.M_AXIS_PHASE_tlast) last_b1 = bus.M_AXIS_PHASE_tdata;
          else                        last_b0 = bus.M_AXIS_PHASE_tdata;
        end
        prev_stall = bus.M_AXIS_PHASE_tvalid && !bus.M_AXIS_PHASE_tready;
        prev_data  = bus.M_AXIS_PHASE_tdata;
      end
    end
  end

  initial begin
    rst = 1'b0;
    en = 1'b0;
    clear_ovf = 1'b0;
    bus.S_AXIS_PI_A_tvalid = 1'b0;
    bus.S_AXIS_PI_B_tvalid = 1'b0;
    bus.S_AXIS_PI_A_tdata = '0;
    bus.S_AXIS_PI_B_tdata = '0;
    bus.M_AXIS_PHASE_tready = 1'b1;
    last_b0 = 32'hDEAD_BEEF;
    last_b1 = 32'hDEAD_BEEF;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_tvalid", bus.M_AXIS_PHASE_tvalid, 1'b0);
    check_eq("rst_tdata", bus.M_AXIS_PHASE_tdata, 32'h0);
    check_eq("rst_tlast", bus.M_AXIS_PHASE_tlast, 1'b0);
    check_eq("rst_overflow", overflow, 1'b0);
    rst = 1'b1;

    // Constant rate +5/+2
    clean();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 32'd5, 32'd2, 1'b1);
      if (i == 2) check_eq("cr_lat_before", bus.M_AXIS_PHASE_tvalid, 1'b0);
      if (i == 3) begin
        check_eq("cr_lat_valid", bus.M_AXIS_PHASE_tvalid, 1'b1);
        check_eq("cr_pkt0_beat0", bus.M_AXIS_PHASE_tdata, 32'h0000_0000);
      end
      if (i == 4) check_eq("cr_pkt0_beat1", bus.M_AXIS_PHASE_tdata, 32'h0000_000C);
      if (i == 7) check_eq("cr_pkt1_beat0", bus.M_AXIS_PHASE_tdata, 32'h0001_0000);
      if (i == 8) check_eq("cr_pkt1_beat1", bus.M_AXIS_PHASE_tdata, 32'h0000_0018);
    end
    drain(3);
    check_eq("cr_last_b0", last_b0, 32'h0002_0000);
    check_eq("cr_last_b1", last_b1, 32'h0000_0024);
    check_eq("cr_overflow", overflow, 1'b0);

    // Negative wrap
    clean();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b1);
    drain(3);
    check_eq("neg_beat0", last_b0, 32'h0000_FFFF);
    check_eq("neg_beat1", last_b1, 32'hFFFF_FFFC);
    check_eq("neg_overflow", overflow, 1'b0);

    // Valid gating
    clean();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i[0], 32'd1, 32'd0, 1'b1);
      if (i == 6) check_eq("gate_no_pkt_yet", bus.M_AXIS_PHASE_tvalid, 1'b0);
      if (i == 7) check_eq("gate_pkt_valid", bus.M_AXIS_PHASE_tvalid, 1'b1);
    end
    drain(3);
    check_eq("gate_beat1", last_b1, 32'h0000_0004);

    // Back-pressure drops the seq=1 snapshot
    clean();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'd5, 32'd2, 1'b1);
    for (int i = 0; i < 12; i++) begin
      if (i < 4) step(1'b1, 1'b1, 32'd5, 32'd2, 1'b0);
      else       step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    end
    check_eq("bp_overflow_set", overflow, 1'b1);
    check_eq("bp_overflow_model", overflow, m_ovf);
    check_eq("bp_held_tlast", bus.M_AXIS_PHASE_tlast, 1'b0);
    drain(2);
    check_eq("bp_pkt0_beat1", last_b1, 32'h0000_000C);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'd5, 32'd2, 1'b1);
    drain(3);
    check_eq("bp_next_seq", {16'h0, last_b0[31:16]}, 32'd2);
    check_eq("bp_next_beat1", last_b1, 32'h0000_0024);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1);
    check_eq("bp_overflow_clr", overflow, 1'b0);

    // Beat1 handshake coincides with a snapshot
    clean();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 32'd5, 32'd2, !(i == 5 || i == 6));
    check_eq("sim_tvalid", bus.M_AXIS_PHASE_tvalid, 1'b1);
    check_eq("sim_tlast", bus.M_AXIS_PHASE_tlast, 1'b0);
    check_eq("sim_beat0", bus.M_AXIS_PHASE_tdata, 32'h0001_0000);
    check_eq("sim_overflow", overflow, 1'b0);
    drain(3);
    check_eq("sim_beat1", last_b1, 32'h0000_0018);

    // Asynchronous reset while in BEAT1
    clean();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'd5, 32'd2, 1'b1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    check_eq("rr_in_beat1", bus.M_AXIS_PHASE_tlast, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    check_eq("rr_tvalid_drop", bus.M_AXIS_PHASE_tvalid, 1'b0);
    check_eq("rr_tdata_clr", bus.M_AXIS_PHASE_tdata, 32'h0);
    check_eq("rr_tlast_clr", bus.M_AXIS_PHASE_tlast, 1'b0);
    model_reset();
    last_b0 = 32'hDEAD_BEEF;
    last_b1 = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'd7, 32'd1, 1'b1);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'd5, 32'd2, 1'b1);
    drain(3);
    check_eq("rr_seq0", last_b0, 32'h0000_0000);
    check_eq("rr_beat1", last_b1, 32'h0000_000C);
    check_eq("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
